// File: rtl/mhp_tx_buffer.sv
// Store-and-forward frame buffer between the MHP frame assembler and the link transmitter.
// Frames are released only once complete; frames that overflow the buffer or exceed MAX_FRAME are dropped whole.
module mhp_tx_buffer #(
  parameter int DEPTH_LOG2 = 7,
  parameter int MAX_FRAME  = 51
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            i_wdata,
  input  logic                  i_wvalid,
  input  logic                  i_done,
  output logic [7:0]            o_tdata,
  output logic                  o_tvalid,
  input  logic                  i_tready,
  output logic                  o_tlast,
  output logic [DEPTH_LOG2:0]   o_frames,
  output logic                  o_drop
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = $clog2(MAX_FRAME + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_FRAME);

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_FILL,
    WR_DISCARD
  } wr_state_e;

  logic [8:0]            mem_q [DEPTH];
  wr_state_e             state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] wr_commit_q, wr_commit_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  drop_q, drop_d;
  logic [7:0]            tdata_q, tdata_d;
  logic                  tlast_q, tlast_d;
  logic                  tvalid_q, tvalid_d;
  logic [DEPTH_LOG2:0]   frames_q, frames_d;

  logic [DEPTH_LOG2-1:0] wr_ptr_inc;
  logic                  full;
  logic                  mem_we;
  logic                  commit;
  logic                  pop_last;
  logic                  avail;
  logic                  load;
  logic [8:0]            rd_entry;

  // Write side: full is judged on pre-edge pointers, so a same-cycle freeing read does not help.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    cnt_d       = cnt_q;
    drop_d      = 1'b0;
    mem_we      = 1'b0;
    commit      = 1'b0;
    wr_ptr_inc  = wr_ptr_q + 1'b1;
    full        = (wr_ptr_inc == rd_ptr_q);
    case (state_q)
      WR_IDLE, WR_FILL: begin
        if (i_wvalid) begin
          if (!full && (cnt_q < MAX_CNT)) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_inc;
            cnt_d    = cnt_q + 1'b1;
            state_d  = WR_FILL;
            if (i_done) begin
              wr_commit_d = wr_ptr_inc;
              cnt_d       = '0;
              commit      = 1'b1;
              state_d     = WR_IDLE;
            end
          end else begin
            wr_ptr_d = wr_commit_q;
            if (i_done) begin
              drop_d  = 1'b1;
              cnt_d   = '0;
              state_d = WR_IDLE;
            end else begin
              state_d = WR_DISCARD;
            end
          end
        end
      end
      WR_DISCARD: begin
        if (i_wvalid && i_done) begin
          drop_d   = 1'b1;
          cnt_d    = '0;
          wr_ptr_d = wr_commit_q;
          state_d  = WR_IDLE;
        end
      end
      default: state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= {i_done, i_wdata};
    end
  end

  // Read side: only entries behind wr_commit are ever presented.
  always_comb begin
    rd_entry = mem_q[rd_ptr_q];
    avail    = (rd_ptr_q != wr_commit_q);
    load     = avail && (!tvalid_q || i_tready);
    pop_last = tvalid_q && i_tready && tlast_q;
    rd_ptr_d = rd_ptr_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    if (load) begin
      tdata_d  = rd_entry[7:0];
      tlast_d  = rd_entry[8];
      tvalid_d = 1'b1;
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else if (i_tready) begin
      tvalid_d = 1'b0;
    end
  end

  always_comb begin
    frames_d = frames_q;
    case ({commit, pop_last})
      2'b10:   frames_d = frames_q + 1'b1;
      2'b01:   frames_d = frames_q - 1'b1;
      default: frames_d = frames_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WR_IDLE;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      drop_q      <= 1'b0;
      tdata_q     <= '0;
      tlast_q     <= 1'b0;
      tvalid_q    <= 1'b0;
      frames_q    <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      drop_q      <= drop_d;
      tdata_q     <= tdata_d;
      tlast_q     <= tlast_d;
      tvalid_q    <= tvalid_d;
      frames_q    <= frames_d;
    end
  end

  assign o_tdata  = tdata_q;
  assign o_tlast  = tlast_q;
  assign o_tvalid = tvalid_q;
  assign o_frames = frames_q;
  assign o_drop   = drop_q;

endmodule

// File: tb/tb_mhp_tx_buffer.sv
// Directed bench for mhp_tx_buffer: a default-depth instance and a 63-byte instance share all inputs.
module tb_mhp_tx_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i_wdata;
  logic       i_wvalid;
  logic       i_done;
  logic       i_tready;

  logic [7:0] a_tdata, b_tdata;
  logic       a_tvalid, b_tvalid;
  logic       a_tlast, b_tlast;
  logic [7:0] a_frames;
  logic [6:0] b_frames;
  logic       a_drop, b_drop;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  logic [7:0] qa_d[$], qb_d[$];
  logic       qa_l[$], qb_l[$];
  int         qa_c[$];
  int         drops_a, drops_b, peak_a, stalls, stall_err;
  logic       stall_prev;
  logic [9:0] stall_val;

  mhp_tx_buffer #(.DEPTH_LOG2(7), .MAX_FRAME(51)) u_a (
    .clk(clk), .rst(rst), .i_wdata(i_wdata), .i_wvalid(i_wvalid), .i_done(i_done),
    .o_tdata(a_tdata), .o_tvalid(a_tvalid), .i_tready(i_tready), .o_tlast(a_tlast),
    .o_frames(a_frames), .o_drop(a_drop)
  );

  mhp_tx_buffer #(.DEPTH_LOG2(6), .MAX_FRAME(51)) u_b (
    .clk(clk), .rst(rst), .i_wdata(i_wdata), .i_wvalid(i_wvalid), .i_done(i_done),
    .o_tdata(b_tdata), .o_tvalid(b_tvalid), .i_tready(i_tready), .o_tlast(b_tlast),
    .o_frames(b_frames), .o_drop(b_drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n++;

  // Capture accepted bytes and watch output stability while stalled.
  always @(negedge clk) begin
    if (a_tvalid === 1'b1 && i_tready === 1'b1) begin
      qa_d.push_back(a_tdata);
      qa_l.push_back(a_tlast);
      qa_c.push_back(cyc_n);
    end
    if (b_tvalid === 1'b1 && i_tready === 1'b1) begin
      qb_d.push_back(b_tdata);
      qb_l.push_back(b_tlast);
    end
    if (a_drop === 1'b1) drops_a++;
    if (b_drop === 1'b1) drops_b++;
    if (int'(a_frames) > peak_a) peak_a = int'(a_frames);
    if (rst === 1'b1) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && ({a_tvalid, a_tlast, a_tdata} !== stall_val)) stall_err++;
      stall_prev = (a_tvalid === 1'b1) && (i_tready === 1'b0);
      stall_val  = {a_tvalid, a_tlast, a_tdata};
      if (stall_prev) stalls++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    qa_d.delete(); qa_l.delete(); qa_c.delete();
    qb_d.delete(); qb_l.delete();
    drops_a = 0; drops_b = 0; peak_a = 0; stalls = 0; stall_err = 0;
  endtask

  task automatic reset_dut();
    rst = 1'b1; i_wvalid = 1'b0; i_done = 1'b0; i_wdata = '0;
    cyc(); cyc();
    rst = 1'b0;
    clear_mon();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    i_wvalid = 1'b1; i_wdata = d; i_done = last;
    cyc();
    i_wvalid = 1'b0; i_done = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] base, input int len);
    for (int i = 0; i < len; i++) send_byte(base + 8'(i), i == len - 1);
  endtask

  task automatic check_seq(input string tag, input bit sel, input int n,
                           input logic [7:0] first, input int flen);
    int sz;
    logic [7:0] d;
    logic l;
    sz = sel ? qb_d.size() : qa_d.size();
    chk({tag, "_count"}, 32'(sz), 32'(n));
    for (int i = 0; i < n && i < sz; i++) begin
      d = sel ? qb_d[i] : qa_d[i];
      l = sel ? qb_l[i] : qa_l[i];
      chk($sformatf("%s_data%0d", tag, i), 32'(d), 32'(first + 8'(i)));
      chk($sformatf("%s_last%0d", tag, i), 32'(l), 32'(((i + 1) % flen) == 0));
    end
  endtask

  function automatic int span_a();
    if (qa_c.size() == 0) return -1;
    return qa_c[qa_c.size() - 1] - qa_c[0];
  endfunction

  initial begin
    logic [15:0] pat;
    pat = 16'b1001_0110_0011_1001;
    i_tready = 1'b1;
    stall_prev = 1'b0;
    stall_val = '0;

    // Reset state
    reset_dut();
    chk("rst_a_tvalid", 32'(a_tvalid), 0);
    chk("rst_a_tdata",  32'(a_tdata), 0);
    chk("rst_a_tlast",  32'(a_tlast), 0);
    chk("rst_a_frames", 32'(a_frames), 0);
    chk("rst_a_drop",   32'(a_drop), 0);
    chk("rst_b_tvalid", 32'(b_tvalid), 0);
    chk("rst_b_frames", 32'(b_frames), 0);

    // Single 9-byte frame with commit-to-output latency
    i_tready = 1'b1;
    send_frame(8'h01, 9);
    chk("t1_tvalid_at_commit", 32'(a_tvalid), 0);
    chk("t1_frames_commit", 32'(a_frames), 1);
    cyc();
    chk("t1_tvalid_next", 32'(a_tvalid), 1);
    chk("t1_first_byte", 32'(a_tdata), 32'h01);
    repeat (12) cyc();
    check_seq("t1", 1'b0, 9, 8'h01, 9);
    chk("t1_span", 32'(span_a()), 8);
    chk("t1_frames_end", 32'(a_frames), 0);

    // Two back-to-back 51-byte frames
    reset_dut();
    i_tready = 1'b1;
    send_frame(8'h00, 51);
    send_frame(8'h33, 51);
    repeat (60) cyc();
    check_seq("t2", 1'b0, 102, 8'h00, 51);
    chk("t2_span", 32'(span_a()), 101);
    chk("t2_peak", 32'(peak_a), 2);
    chk("t2_frames_end", 32'(a_frames), 0);

    // Backpressure on a 20-byte frame
    reset_dut();
    for (int k = 0; k < 100; k++) begin
      i_tready = pat[k % 16];
      if (k < 20) send_byte(8'h40 + 8'(k), k == 19);
      else cyc();
    end
    i_tready = 1'b1;
    repeat (5) cyc();
    check_seq("t3", 1'b0, 20, 8'h40, 20);
    chk("t3_stall_stable", 32'(stall_err), 0);
    chk("t3_stalls_seen", 32'(stalls > 0), 1);

    // Overflow in the 63-byte instance
    reset_dut();
    i_tready = 1'b0;
    send_frame(8'h10, 51);
    send_frame(8'h80, 51);
    chk("t4_drop_pulse", 32'(b_drop), 1);
    cyc();
    chk("t4_drop_low", 32'(b_drop), 0);
    chk("t4_drop_count", 32'(drops_b), 1);
    chk("t4_b_frames", 32'(b_frames), 1);
    chk("t4_a_frames", 32'(a_frames), 2);
    chk("t4_a_no_drop", 32'(drops_a), 0);
    i_tready = 1'b1;
    repeat (120) cyc();
    check_seq("t4", 1'b1, 51, 8'h10, 51);
    chk("t4_b_frames_end", 32'(b_frames), 0);

    // Oversize frame then a normal frame
    reset_dut();
    i_tready = 1'b1;
    send_frame(8'h90, 52);
    chk("t5_drop_pulse", 32'(a_drop), 1);
    cyc();
    chk("t5_drop_low", 32'(a_drop), 0);
    repeat (5) cyc();
    chk("t5_nothing_out", 32'(qa_d.size()), 0);
    chk("t5_frames", 32'(a_frames), 0);
    send_frame(8'hA0, 10);
    repeat (15) cyc();
    check_seq("t5", 1'b0, 10, 8'hA0, 10);
    chk("t5_drop_count", 32'(drops_a), 1);

    // Reset mid-frame with a committed frame buffered
    reset_dut();
    i_tready = 1'b0;
    send_frame(8'h20, 9);
    for (int i = 0; i < 5; i++) send_byte(8'h50 + 8'(i), 1'b0);
    chk("t6_frames_pre", 32'(a_frames), 1);
    chk("t6_tvalid_pre", 32'(a_tvalid), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t6_tvalid", 32'(a_tvalid), 0);
    chk("t6_tdata",  32'(a_tdata), 0);
    chk("t6_tlast",  32'(a_tlast), 0);
    chk("t6_frames", 32'(a_frames), 0);
    chk("t6_drop",   32'(a_drop), 0);
    qa_d.delete(); qa_l.delete(); qa_c.delete();
    i_tready = 1'b1;
    send_frame(8'h31, 9);
    repeat (15) cyc();
    check_seq("t6", 1'b0, 9, 8'h31, 9);
    chk("t6_no_drop", 32'(drops_a), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mhp_tx_buffer.md
# mhp_tx_buffer

Store-and-forward byte buffer directly downstream of the MHP frame assembler. Accepts the assembler's unthrottled byte stream (data/valid plus end-of-frame `done`), holds each frame until its last byte arrives, then releases whole frames to the link transmitter over a valid/ready byte interface with an end-of-frame marker. Frames that do not fit are dropped whole, never truncated.

## Interface
- `DEPTH_LOG2`, default 7: buffer holds 2^DEPTH_LOG2 − 1 bytes (one slot reserved for full detection).
- `MAX_FRAME`, default 51: largest legal MHP frame in bytes (9-byte overhead + 42 payload).
- `clk` input 1: single clock, all logic rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `i_wdata` input 8: byte from assembler.
- `i_wvalid` input 1: `i_wdata` valid this cycle; no backpressure toward assembler.
- `i_done` input 1: assembler done; `i_wvalid && i_done` marks the last byte of a frame.
- `o_tdata` output 8: byte to transmitter.
- `o_tvalid` output 1: `o_tdata`/`o_tlast` valid.
- `i_tready` input 1: transmitter accepts byte when `o_tvalid && i_tready`.
- `o_tlast` output 1: current output byte is last of its frame.
- `o_frames` output DEPTH_LOG2+1: committed frames not yet fully read out (including one partially in output).
- `o_drop` output 1: one-cycle pulse when a frame is discarded.

## Operation
- Storage: 2^DEPTH_LOG2 entries × 9 bits {last, data}. Pointers `wr_ptr`, `wr_commit`, `rd_ptr`, all DEPTH_LOG2 bits, wrap modulo depth.
- Write side states: WR_IDLE (no frame open), WR_FILL (frame open, bytes being stored), WR_DISCARD (frame being dropped).
  - WR_IDLE/WR_FILL, `i_wvalid`: if not full (`wr_ptr+1 != rd_ptr`) and frame byte count < MAX_FRAME, store {i_done, i_wdata} at `wr_ptr`, `wr_ptr++`, byte count++; go WR_FILL. Otherwise go WR_DISCARD, `wr_ptr <= wr_commit`.
  - Last byte stored (`i_done`): `wr_commit <= wr_ptr+1`, byte count cleared, `o_frames++`, return WR_IDLE.
  - WR_DISCARD: ignore bytes; on `i_wvalid && i_done` pulse `o_drop`, byte count cleared, `wr_ptr <= wr_commit`, return WR_IDLE. If the overflowing byte itself carries `i_done`, drop and return to WR_IDLE in that same cycle.
  - `i_done` without `i_wvalid` is ignored.
- Read side: data available when `rd_ptr != wr_commit`. Output register loads entry at `rd_ptr`, `rd_ptr++`, when available and (`!o_tvalid` or `i_tready`). Holds `o_tdata`/`o_tlast`/`o_tvalid` stable while `o_tvalid && !i_tready`.
- `o_frames`: decrement when a byte with `o_tlast` is accepted (`o_tvalid && i_tready && o_tlast`); commit and accept-of-last in same cycle leaves it unchanged.
- Uncommitted bytes are never visible at the output; frames leave in arrival order, bytes in order, exactly once.

## Timing
- Reset: `o_tdata`=0, `o_tvalid`=0, `o_tlast`=0, `o_frames`=0, `o_drop`=0; all pointers and byte count 0; write state WR_IDLE. Reset mid-frame discards everything, buffered and in-flight, without an `o_drop` pulse.
- Write accepted every cycle `i_wvalid` is high; sustained 1 byte/cycle.
- Latency: last byte written at edge E; `o_tvalid` first high after edge E+1 (first byte of frame appears one cycle after commit) if output empty.
- Read throughput 1 byte/cycle with `i_tready` held high; back-to-back frames have no idle cycle between them.
- Full and write of last slot-freeing read in same cycle: full evaluated on pre-edge pointers (write drops).
- `o_drop` registered, high exactly one cycle, the cycle after the edge that consumed the dropped frame's last byte.

## Test plan
- Single frame, 9 bytes 0x01..0x09, `i_done` with 0x09, `i_tready`=1 -> `o_tvalid` starts one cycle after commit, 9 consecutive bytes 0x01..0x09, `o_tlast` only on 0x09, `o_frames` 1 then 0.
- Two back-to-back 51-byte frames, `i_tready`=1 -> 102 bytes in order, `o_tlast` at bytes 51 and 102, no gap cycle, `o_frames` peaks at 2.
- Backpressure: `i_tready` toggled 1-0-0-1 pseudo-randomly during 20-byte frame -> `o_tdata` stable while stalled, no byte lost or duplicated.
- Overflow, DEPTH_LOG2=6 (63 bytes), `i_tready`=0, send 51-byte frame then 51-byte frame -> first kept, second dropped, one `o_drop` pulse, `o_frames`=1; release ready -> exactly first frame out.
- Oversize: 52-byte frame -> `o_drop` pulse, nothing output; following 10-byte frame delivered intact.
- Reset after 5 bytes of a frame with 1 committed frame buffered -> all outputs 0, `o_frames`=0; next 9-byte frame delivered correctly.
